// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage; PC, imem request/response ports, decode buffer, redirect flush
// Ports: clk, rst (async active-high); imem_req_valid/ready/addr request port;
// imem_rsp_valid/data in-order response port; redirect_valid/addr taken-branch target;
// id_valid/ready/pc/instr decode handoff from the buffer head.
// Define FETCH_PERF_EN to add saturating perf_redirects, perf_dropped, perf_req_stall outputs.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_dropped,
  output logic [31:0] perf_req_stall
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1) + 1;
  typedef enum logic {BOOT, FETCH} state_t;
  state_t state_q, state_d;
  logic fetch, hs, deq, redir, drop, push;
  logic [31:0] pc_q;
  logic [CW-1:0] inflight, drop_cnt, occ, outstanding;
  logic [AW-1:0] q_wr, q_rd, b_wr, b_rd;
  logic [31:0] q_pc [DEPTH];
  logic [31:0] b_pc [DEPTH];
  logic [31:0] b_instr [DEPTH];

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= BOOT;
    else state_q <= state_d;

  always_comb state_d = (state_q == BOOT) ? FETCH : state_q;

  // Issue only while every accepted request is guaranteed a buffer slot on return.
  always_comb begin
    fetch = state_q == FETCH;
    id_valid = occ != '0;
    deq = id_valid && id_ready;
    imem_req_valid = fetch && ((inflight + occ - CW'(deq)) < CW'(DEPTH));
  end

  always_comb begin
    hs = imem_req_valid && imem_req_ready;
    redir = fetch && redirect_valid;
    drop = imem_rsp_valid && (redir || drop_cnt != '0);
    push = imem_rsp_valid && !drop;
    outstanding = inflight + CW'(hs) - CW'(imem_rsp_valid);
    imem_req_addr = pc_q;
    id_pc = b_pc[b_rd];
    id_instr = b_instr[b_rd];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      occ <= '0;
      q_wr <= '0;
      q_rd <= '0;
      b_wr <= '0;
      b_rd <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i] <= '0;
        b_pc[i] <= '0;
        b_instr[i] <= '0;
      end
    end else begin
      pc_q <= redir ? {redirect_addr[31:2], 2'b00} : hs ? pc_q + 32'd4 : pc_q;
      inflight <= outstanding;
      // Every request still outstanding after a redirect belongs to the wrong path.
      drop_cnt <= redir ? outstanding : drop_cnt - CW'(drop);
      if (hs) begin
        q_pc[q_wr] <= pc_q;
        q_wr <= q_wr + AW'(1);
      end
      if (imem_rsp_valid) q_rd <= q_rd + AW'(1);
      if (redir) begin
        occ <= '0;
        b_rd <= b_wr;
      end else begin
        if (push) begin
          b_pc[b_wr] <= q_pc[q_rd];
          b_instr[b_wr] <= imem_rsp_data;
          b_wr <= b_wr + AW'(1);
        end
        if (deq) b_rd <= b_rd + AW'(1);
        occ <= occ + CW'(push) - CW'(deq);
      end
    end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_redirects <= '0;
      perf_dropped <= '0;
      perf_req_stall <= '0;
    end else begin
      perf_redirects <= perf_redirects + 32'(redir && perf_redirects != '1);
      perf_dropped <= perf_dropped + 32'(drop && perf_dropped != '1);
      perf_req_stall <= perf_req_stall + 32'(imem_req_valid && !imem_req_ready && perf_req_stall != '1);
    end
`endif

  a_rsp_expected: assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> inflight != '0);
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage. Owns the architectural fetch PC and issues word requests to instruction memory over a valid/ready request port with an in-order response port. Delivers {pc, instr} pairs to decode through a small buffer. It is the consumer of the branch unit's redirect (taken flag plus target): it flushes wrong-path work and discards stale in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 2: output buffer entries; also the cap on in-flight requests (power of two, ≥2).

Ports:
- `clk` in 1: clock. One clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_req_valid` out 1: request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out 32: word address; bits [1:0] are always 0.
- `imem_rsp_valid` in 1: response valid. No backpressure. Responses arrive in order, at least 1 cycle after the request handshake.
- `imem_rsp_data` in 32: instruction word.
- `redirect_valid` in 1: taken branch or jump resolved in EX.
- `redirect_addr` in 32: target address. Bits [1:0] are ignored and treated as 0.
- `id_valid` out 1: decode entry valid. Driven from the buffer head register.
- `id_ready` in 1: decode accepts.
- `id_pc` out 32: PC of the head entry.
- `id_instr` out 32: instruction of the head entry.

## Operation
- FSM states: BOOT, FETCH.
  - Reset enters BOOT. BOOT lasts exactly one cycle with no request, then moves to FETCH. FETCH persists until reset.
- `pc_q`:
  - Reset value is `RESET_PC`.
  - Advances by 4 on each request handshake (`imem_req_valid && imem_req_ready`).
  - Wraps modulo 2^32: 0xFFFF_FFFC → 0x0000_0000.
- Issue rule: `imem_req_valid` = FETCH && (inflight + occupancy − deq) < DEPTH, where deq = `id_valid && id_ready`.
  - This sustains 1 instr/cycle with a 1-cycle memory.
- While `imem_req_valid && !imem_req_ready`, `imem_req_addr` holds stable unless a redirect occurs.
- In-flight PC queue (DEPTH entries) records the address of each accepted request. Each response pops it and pairs its PC with `imem_rsp_data`.
- Counters:
  - `inflight` range is 0..DEPTH.
  - `drop_cnt` range is 0..DEPTH. While `drop_cnt` > 0, each response is discarded and decrements `drop_cnt`; it is not written to the buffer.
- Redirect (`redirect_valid`=1 in FETCH):
  - `pc_q` ← {redirect_addr[31:2], 2'b00}.
  - Output buffer is cleared, including any entry handed to decode in that same cycle. Decode treats a redirect as a flush.
  - `drop_cnt` ← number of requests still outstanding after this cycle. This includes a request handshaked in the redirect cycle and excludes a response arriving in the redirect cycle, which is itself dropped.
  - `imem_req_addr` shows the target on the following cycle.
- Back-to-back redirects: the latest one wins. `drop_cnt` is recomputed each time.
- `redirect_valid` in BOOT is ignored.
- A response with `inflight` = 0 is a protocol violation. Behaviour is undefined; simulation asserts on it.

## Timing
- Reset values:
  - `imem_req_valid` = 0, `imem_req_addr` = `RESET_PC`.
  - `id_valid` = 0, `id_pc` = 0, `id_instr` = 0.
  - `inflight` = 0, `drop_cnt` = 0, buffer empty, state BOOT.
- First request is driven 1 cycle after `rst` deasserts.
- Response to decode latency:
  - A response accepted into the buffer in cycle t appears as `id_valid`=1 at t+1.
  - Total request-to-decode latency = memory latency + 1.
- A redirect in cycle t gives a new-target request no earlier than t+1.
  - The first new-target instruction reaches decode no earlier than t+3 with a 1-cycle memory.
- Reset mid-operation: all state is cleared immediately. Responses arriving after reset for requests issued before it are a system error; memory is reset together with this block.

## Configuration
- `FETCH_PERF_EN` defined: adds three outputs, each 32 bits, saturating, reset to 0:
  - `perf_redirects`: count of redirect cycles.
  - `perf_dropped`: count of discarded responses.
  - `perf_req_stall`: count of cycles with `imem_req_valid && !imem_req_ready`.
- Not defined: those ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset release, 1-cycle memory always ready, decode always ready → requests at 0x0, 0x4, 0x8… on consecutive cycles starting 1 cycle after reset; `id_valid` continuous from cycle 3 with matching `id_pc`/`id_instr`.
- `id_ready`=0 for 10 cycles → at most DEPTH=2 requests outstanding plus buffered; no response lost. On release, delivery order 0x0, 0x4, 0x8 is intact.
- Redirect to 0x100 while 2 requests are in flight → both responses dropped (`perf_dropped`=2); next `id_pc` = 0x100; no old-path entry reaches decode.
- Redirect coincident with a response and a request handshake → that response is dropped, the just-issued request's response is dropped later, and the target fetch follows.
- `redirect_addr`=0x203 → fetch from 0x200. `pc_q` at 0xFFFF_FFFC wraps to 0x0.
- `imem_req_ready` toggling, 3-cycle memory latency → `imem_req_addr` stable while stalled; `perf_req_stall` equals the stalled cycle count; in-order delivery.
